// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Shares one I2C master between two sensor controllers. Each requester owns
//   a one-deep pending slot; a round-robin FSM (IDLE/ISSUE/WAIT/GAP) issues
//   one transaction at a time, reports completion or timeout back to the
//   owner, and inserts GAP_CYC idle cycles between bus transactions.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cN_exec/rw/addr/wdata    requester N command (N = 0,1), sampled on exec
//   cN_rdata/done/err/ovf    requester N read byte, done pulse, timeout flag,
//                            sticky dropped-request flag
//   m_exec/rw/addr/wdata     command to the shared I2C master
//   m_rdata, m_done          I2C master response
//   busy                     FSM is not IDLE
module i2c_arbiter #(
  parameter logic [19:0] TIMEOUT = 20'd200_000,
  parameter logic [7:0]  GAP_CYC = 8'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_exec,
  input  logic        c0_rw,
  input  logic [15:0] c0_addr,
  input  logic [7:0]  c0_wdata,
  output logic [7:0]  c0_rdata,
  output logic        c0_done,
  output logic        c0_err,
  output logic        c0_ovf,
  input  logic        c1_exec,
  input  logic        c1_rw,
  input  logic [15:0] c1_addr,
  input  logic [7:0]  c1_wdata,
  output logic [7:0]  c1_rdata,
  output logic        c1_done,
  output logic        c1_err,
  output logic        c1_ovf,
  output logic        m_exec,
  output logic        m_rw,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic        m_done,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]       exec_in, rw_in;
  logic [1:0][15:0] addr_in;
  logic [1:0][7:0]  wdata_in;

  assign exec_in  = {c1_exec, c0_exec};
  assign rw_in    = {c1_rw, c0_rw};
  assign addr_in  = {c1_addr, c0_addr};
  assign wdata_in = {c1_wdata, c0_wdata};

  logic [1:0]       slot_v, slot_rw;
  logic [1:0][15:0] slot_addr;
  logic [1:0][7:0]  slot_wdata;
  logic [1:0]       done_q, err_q, ovf_q;
  logic [1:0][7:0]  rdata_q;

  logic [1:0]  state;
  logic        owner, last, grant, finish;
  logic [1:0]  clr;
  logic [19:0] wait_cnt;
  logic [7:0]  gap_cnt;

  // Tie goes to whoever was not granted last; otherwise the lone requester.
  always_comb begin
    grant  = (slot_v == 2'b11) ? ~last : slot_v[1];
    finish = (state == WAIT) && (m_done || (wait_cnt == TIMEOUT - 20'd1));
    clr    = finish ? (2'b01 << owner) : 2'b00;
  end

  // Pending slots. An exec against a valid slot (even one being cleared this
  // cycle) is dropped and flagged; the clear is applied after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v     <= '0;
      slot_rw    <= '0;
      slot_addr  <= '0;
      slot_wdata <= '0;
      ovf_q      <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (exec_in[i]) begin
          if (slot_v[i]) begin
            ovf_q[i] <= 1'b1;
          end else begin
            slot_v[i]     <= 1'b1;
            slot_rw[i]    <= rw_in[i];
            slot_addr[i]  <= addr_in[i];
            slot_wdata[i] <= wdata_in[i];
          end
        end
        if (clr[i]) slot_v[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      m_exec   <= 1'b0;
      m_rw     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      m_exec <= 1'b0;
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: begin
          if (|slot_v) begin
            owner <= grant;
            last  <= grant;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          m_exec   <= 1'b1;
          m_rw     <= slot_rw[owner];
          m_addr   <= slot_addr[owner];
          m_wdata  <= slot_wdata[owner];
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (finish) begin
            done_q[owner] <= 1'b1;
            err_q[owner]  <= ~m_done;
            if (m_done) rdata_q[owner] <= m_rdata;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            wait_cnt <= wait_cnt + 20'd1;
          end
        end
        default: begin
          // GAP always lasts at least one cycle, GAP_CYC cycles otherwise.
          if (gap_cnt + 8'd1 >= GAP_CYC) state <= IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign c0_done  = done_q[0];
  assign c1_done  = done_q[1];
  assign c0_err   = err_q[0];
  assign c1_err   = err_q[1];
  assign c0_ovf   = ovf_q[0];
  assign c1_ovf   = ovf_q[1];
  assign c0_rdata = rdata_q[0];
  assign c1_rdata = rdata_q[1];

endmodule
